// File: rtl/servo_pwm_driver_if.sv
// Controller-facing bundle of the servo PWM driver: timebase clear/count and
// the per-motor reset/direction codes.
interface servo_pwm_driver_if #(
    parameter int CNT_W = 21
);
    logic             count_reset;
    logic [CNT_W-1:0] count_out;
    logic             motor_l_reset;
    logic [1:0]       motor_l_direction;
    logic             motor_r_reset;
    logic [1:0]       motor_r_direction;

    modport master (
        output count_reset,
        output motor_l_reset,
        output motor_l_direction,
        output motor_r_reset,
        output motor_r_direction,
        input  count_out
    );

    modport slave (
        input  count_reset,
        input  motor_l_reset,
        input  motor_l_direction,
        input  motor_r_reset,
        input  motor_r_direction,
        output count_out
    );
endinterface

// File: rtl/servo_pwm_driver.sv
// Motor-side end of the direction controller link: a saturating timebase and
// two independent one-shot servo PWM channels (left = 0, right = 1).
module servo_pwm_driver #(
    parameter int CNT_W     = 21,
    parameter int PW_W      = 18,
    parameter int PULSE_CW  = 130000,
    parameter int PULSE_CCW = 170000,
    parameter int PULSE_STP = 150000
) (
    input  logic               clk,
    input  logic               reset,
    servo_pwm_driver_if.slave  ctrl,
    output logic               pwm_l,
    output logic               pwm_r
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [PW_W-1:0]  W_CW    = PW_W'(PULSE_CW);
    localparam logic [PW_W-1:0]  W_CCW   = PW_W'(PULSE_CCW);
    localparam logic [PW_W-1:0]  W_STP   = PW_W'(PULSE_STP);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state is written with <= so every register samples the
    // pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (ctrl.count_reset) begin
            count_q <= '0;
        end else if (count_q != CNT_MAX) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign ctrl.count_out = count_q;

    // Codes 00 and 11 both map to the neutral (stop) width.
    function automatic logic [PW_W-1:0] width_of(input logic [1:0] dir);
        case (dir)
            2'b01:   return W_CW;
            2'b10:   return W_CCW;
            default: return W_STP;
        endcase
    endfunction

    logic [1:0] ch_reset;
    logic [1:0] ch_dir [2];

    assign ch_reset  = {ctrl.motor_r_reset, ctrl.motor_l_reset};
    assign ch_dir[0] = ctrl.motor_l_direction;
    assign ch_dir[1] = ctrl.motor_r_direction;

    for (genvar i = 0; i < 2; i++) begin : g_ch
        state_t          state;
        logic [PW_W-1:0] pw_cnt;
        logic            pwm;

        // The counter is loaded with W on IDLE->HIGH and the output falls on the
        // edge that sees it at 1, giving exactly W high cycles.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state  <= IDLE;
                pw_cnt <= '0;
                pwm    <= 1'b0;
            end else if (ch_reset[i]) begin
                state <= IDLE;
                pwm   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        pw_cnt <= width_of(ch_dir[i]);
                        state  <= HIGH;
                        pwm    <= 1'b1;
                    end
                    HIGH: begin
                        pw_cnt <= pw_cnt - PW_W'(1);
                        if (pw_cnt == PW_W'(1)) begin
                            state <= LOW;
                            pwm   <= 1'b0;
                        end
                    end
                    default: begin
                        state <= LOW;
                        pwm   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pwm_l = g_ch[0].pwm;
    assign pwm_r = g_ch[1].pwm;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Scoreboard bench for servo_pwm_driver with scaled-down widths: stimulus queues
// expected pulse widths, negedge monitors measure and compare each pulse.
module tb_servo_pwm_driver;

    localparam int CNT_W     = 8;
    localparam int PW_W      = 5;
    localparam int PULSE_CW  = 13;
    localparam int PULSE_CCW = 17;
    localparam int PULSE_STP = 15;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic pwm_l;
    logic pwm_r;

    servo_pwm_driver_if #(.CNT_W(CNT_W)) ctrl ();

    servo_pwm_driver #(
        .CNT_W    (CNT_W),
        .PW_W     (PW_W),
        .PULSE_CW (PULSE_CW),
        .PULSE_CCW(PULSE_CCW),
        .PULSE_STP(PULSE_STP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ctrl (ctrl),
        .pwm_l(pwm_l),
        .pwm_r(pwm_r)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_l[$];
    int exp_r[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitors: a pulse aborted by the async reset is discarded.
    int   hi_l   = 0;
    int   hi_r   = 0;
    logic prev_l = 1'b0;
    logic prev_r = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            hi_l   = 0;
            prev_l = 1'b0;
        end else begin
            if (pwm_l === 1'b1) begin
                hi_l++;
            end else if (prev_l) begin
                if (exp_l.size() == 0) check("pwm_l unexpected pulse", hi_l, 0);
                else                   check("pwm_l width", hi_l, exp_l.pop_front());
                hi_l = 0;
            end
            prev_l = (pwm_l === 1'b1);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            hi_r   = 0;
            prev_r = 1'b0;
        end else begin
            if (pwm_r === 1'b1) begin
                hi_r++;
            end else if (prev_r) begin
                if (exp_r.size() == 0) check("pwm_r unexpected pulse", hi_r, 0);
                else                   check("pwm_r width", hi_r, exp_r.pop_front());
                hi_r = 0;
            end
            prev_r = (pwm_r === 1'b1);
        end
    end

    task automatic pulse_l(input logic [1:0] dir, input int w);
        ctrl.motor_l_direction = dir;
        ctrl.motor_l_reset     = 1'b0;
        exp_l.push_back(w);
        @(negedge clk);
        check("pwm_l rise latency", pwm_l, 1);
        tick(w + 4);
        check("pwm_l held low after pulse", pwm_l, 0);
        ctrl.motor_l_reset = 1'b1;
        tick(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl.count_reset       = 1'b0;
        ctrl.motor_l_reset     = 1'b1;
        ctrl.motor_r_reset     = 1'b1;
        ctrl.motor_l_direction = 2'b00;
        ctrl.motor_r_direction = 2'b00;

        // Reset state and free-running timebase
        repeat (5) begin
            @(negedge clk);
            check("reset count_out", ctrl.count_out, 0);
            check("reset pwm_l", pwm_l, 0);
            check("reset pwm_r", pwm_r, 0);
        end
        reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("count_out increment", ctrl.count_out, i);
            check("pwm_l idle", pwm_l, 0);
            check("pwm_r idle", pwm_r, 0);
        end

        // Clear, saturation, clear at saturation
        tick(194);
        check("count_out before clear", ctrl.count_out, 200);
        ctrl.count_reset = 1'b1;
        @(negedge clk);
        check("count_out cleared", ctrl.count_out, 0);
        ctrl.count_reset = 1'b0;
        tick(CNT_MAX);
        check("count_out reaches max", ctrl.count_out, CNT_MAX);
        tick(10);
        check("count_out saturates", ctrl.count_out, CNT_MAX);
        ctrl.count_reset = 1'b1;
        @(negedge clk);
        check("clear beats saturation", ctrl.count_out, 0);
        ctrl.count_reset = 1'b0;
        @(negedge clk);
        check("count_out restarts", ctrl.count_out, 1);

        // Width per direction code
        pulse_l(2'b01, PULSE_CW);
        pulse_l(2'b10, PULSE_CCW);
        pulse_l(2'b00, PULSE_STP);
        pulse_l(2'b11, PULSE_STP);

        // Direction change during a pulse is ignored until next IDLE
        ctrl.motor_l_direction = 2'b01;
        ctrl.motor_l_reset     = 1'b0;
        exp_l.push_back(PULSE_CW);
        tick(5);
        ctrl.motor_l_direction = 2'b10;
        tick(PULSE_CW + 2);
        ctrl.motor_l_reset = 1'b1;
        tick(2);
        pulse_l(2'b10, PULSE_CCW);

        // Right channel truncated after 6 high cycles, left runs full width
        ctrl.motor_l_direction = 2'b01;
        ctrl.motor_r_direction = 2'b10;
        ctrl.motor_l_reset     = 1'b0;
        ctrl.motor_r_reset     = 1'b0;
        exp_l.push_back(PULSE_CW);
        exp_r.push_back(6);
        tick(6);
        ctrl.motor_r_reset = 1'b1;
        @(negedge clk);
        check("pwm_r forced idle", pwm_r, 0);
        check("pwm_l unaffected", pwm_l, 1);
        ctrl.motor_r_reset = 1'b0;
        exp_r.push_back(PULSE_CCW);
        tick(PULSE_CCW + 4);
        ctrl.motor_l_reset = 1'b1;
        ctrl.motor_r_reset = 1'b1;
        tick(2);

        // Async reset between edges in the middle of both pulses
        ctrl.motor_l_reset = 1'b0;
        ctrl.motor_r_reset = 1'b0;
        tick(4);
        #2;
        reset = 1'b0;
        #1;
        check("async reset pwm_l", pwm_l, 0);
        check("async reset pwm_r", pwm_r, 0);
        check("async reset count_out", ctrl.count_out, 0);
        ctrl.motor_l_reset = 1'b1;
        ctrl.motor_r_reset = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(8);
        check("pwm_l idle after release", pwm_l, 0);
        check("pwm_r idle after release", pwm_r, 0);
        pulse_l(2'b01, PULSE_CW);

        tick(5);
        check("exp_l drained", exp_l.size(), 0);
        check("exp_r drained", exp_r.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
